cdb_wb_arb: RTL and testbench
=============================

Name: cdb_wb_arb

Overview:
Writeback arbiter between the functional-unit lanes and the common data bus (CDB).
- Buffers each FU lane's completed result in a small per-lane FIFO.
- Round-robin grants up to CDB_NUM_LANES results per cycle onto registered CDB ports.
- The CDB feeds the reservation station wakeup and the ROB.
- Drives the fu_free / fu_free_1c back-pressure the reservation station uses to qualify dispatch.

Parameters:
NUM_FU_LANES, 6, number of producing FU lanes (matches CPU_NUM_LANES)
CDB_NUM_LANES, 4, number of CDB broadcast ports per cycle
WB_FIFO_DEPTH, 2, entries per lane FIFO (power of 2, ≥2)
ROB_SIZE_CLOG, 5, ROB id width
DATA_LEN, 32, result width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush; clears all buffered results
fu_res_val  in  NUM_FU_LANES  result valid per FU lane
fu_res_robid  in  NUM_FU_LANES x ROB_SIZE_CLOG  result ROB id
fu_res_op  in  NUM_FU_LANES x 6  opcode tag
fu_res_rd  in  NUM_FU_LANES x 5  architectural dest
fu_res_data  in  NUM_FU_LANES x DATA_LEN  result data
fu_free  out  NUM_FU_LANES  lane FIFO can accept a result this cycle
fu_free_1c  out  NUM_FU_LANES  lane FIFO full, but its head is granted this cycle
commit_instr_cdb  out  CDB_NUM_LANES  CDB port valid
robid_cdb  out  CDB_NUM_LANES x ROB_SIZE_CLOG
op_cdb  out  CDB_NUM_LANES x 6
rd_tag_cdb  out  CDB_NUM_LANES x 5
result_data_cdb  out  CDB_NUM_LANES x DATA_LEN

Behaviour:
Reset:
- Async on rst low.
- All FIFOs empty; rr_ptr = 0.
- All CDB outputs 0.
- fu_free = all 1s; fu_free_1c = 0.

Enqueue:
- fu_res_val[l] is written into FIFO l at the clock edge when fu_free[l] = 1, or when fu_free_1c[l] = 1 (simultaneous push and pop).
- A push while full and not popping is a protocol violation: the result is dropped and a simulation assertion fires.

fu_free[l]:
- Combinational: occupancy[l] < WB_FIFO_DEPTH.

Arbitration (combinational, on registered FIFO state):
- Scan lanes in order rr_ptr, rr_ptr+1, … modulo NUM_FU_LANES.
- The first CDB_NUM_LANES non-empty lanes are granted to CDB ports 0, 1, … in scan order.
- Granted heads pop at the edge.
- rr_ptr_next = (last granted lane + 1) mod NUM_FU_LANES; rr_ptr is unchanged if there is no grant.

CDB outputs:
- Registered. Port c gets commit_instr_cdb[c] = 1 plus the head fields of its granted lane.
- Ungranted ports: commit_instr_cdb = 0, other fields hold their last value.
- Consumers qualify on commit_instr_cdb only.

Latency:
- Result presented before edge E0 is in the FIFO after E0.
- Earliest visible on the CDB after E1 (2 edges).

Boundaries:
- Full and granted in the same cycle: push and pop both happen; occupancy is unchanged.
- More than CDB_NUM_LANES lanes non-empty: the excess waits; the round-robin pointer guarantees each lane is granted within ceil(NUM_FU_LANES / CDB_NUM_LANES) cycles.
- Pointer wrap: lane NUM_FU_LANES-1 is followed by lane 0.
- Flush, synchronous and highest priority:
  - At that edge, all FIFOs are emptied and all commit_instr_cdb are set to 0.
  - Inputs and grants in the flush cycle are discarded; rr_ptr is kept.
- Reset mid-operation: immediate clear; no partial broadcast.

Optional Feature:
CDB_BYPASS_EN
- Defined: a lane whose FIFO is empty with fu_res_val = 1 participates in arbitration directly from its inputs. If granted, the result appears on the CDB after E0 (1 edge) and is not written into the FIFO. Flush still discards it.
- Undefined: no bypass; minimum latency is 2 edges.

Decomposition:
- Package (structs.sv / rtl_constants.sv): cdb_pkt_t {robid, op, rd, data}, plus CDB_NUM_LANES and WB_FIFO_DEPTH constants.
- Sub-module wb_fifo: single-lane FIFO of cdb_pkt_t with push, pop, flush, full, empty and occupancy, instantiated NUM_FU_LANES times.
- The arbiter and CDB output registers stay in cdb_wb_arb.

Test Plan:
1. Reset, then a single result on lane 2 (robid 5, rd 7, data 0xDEADBEEF) -> after 2 edges, port 0 valid with those values; all other ports invalid.
2. All 6 lanes push one result in the same cycle, rr_ptr = 0 -> the next cycle broadcasts lanes 0–3 on ports 0–3, the following cycle lanes 4–5 on ports 0–1; rr_ptr ends at 0.
3. Lane 1 pushes each cycle while other lanes keep CDB saturated -> lane 1 fills to 2 and fu_free[1] = 0; fu_free_1c[1] = 1 on its grant cycle; no result lost.
4. Flush asserted with 3 lanes holding results and a new push on lane 0 -> the next cycle has all commit_instr_cdb = 0, all fu_free = 1, and nothing later broadcast.
5. rr_ptr = 5, lanes 5 and 0 non-empty -> port 0 = lane 5, port 1 = lane 0, rr_ptr_next = 1.
6. With CDB_BYPASS_EN, an empty lane 3 pushes robid 9 -> broadcast after 1 edge; FIFO stays empty.

Source files
------------

// File: rtl/cdb_wb_arb_pkg.sv
// Shared types and constants for the CDB writeback arbiter.
package cdb_wb_arb_pkg;

  localparam int CDB_NUM_LANES = 4;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int ROB_SIZE_CLOG = 5;
  localparam int DATA_LEN      = 32;
  localparam int OP_W          = 6;
  localparam int RD_W          = 5;

  typedef struct packed {
    logic [ROB_SIZE_CLOG-1:0] robid;
    logic [OP_W-1:0]          op;
    logic [RD_W-1:0]          rd;
    logic [DATA_LEN-1:0]      data;
  } cdb_pkt_t;

  function automatic int lane_wrap(input int l, input int n);
    return (l >= n) ? l - n : l;
  endfunction

endpackage

// File: rtl/cdb_wb_arb_wb_fifo.sv
// Single-lane result FIFO; flush empties it and wins over push/pop.
module wb_fifo
  import cdb_wb_arb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  cdb_pkt_t               din_i,
  output cdb_pkt_t               dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] occ_o
);

  localparam int AW = $clog2(DEPTH);

  cdb_pkt_t      mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign dout_o  = mem_q[rp_q];
  assign occ_o   = cnt_q;
  assign full_o  = (int'(cnt_q) == DEPTH);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cdb_wb_arb.sv
// CDB writeback arbiter: per-lane FIFOs, round-robin grant to registered CDB ports.
// Define CDB_BYPASS_EN to let an empty lane's incoming result reach the CDB directly.
module cdb_wb_arb
  import cdb_wb_arb_pkg::*;
#(
  parameter int NUM_FU_LANES = 6
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [NUM_FU_LANES-1:0]                       fu_res_val,
  input  logic [NUM_FU_LANES-1:0][ROB_SIZE_CLOG-1:0]    fu_res_robid,
  input  logic [NUM_FU_LANES-1:0][OP_W-1:0]             fu_res_op,
  input  logic [NUM_FU_LANES-1:0][RD_W-1:0]             fu_res_rd,
  input  logic [NUM_FU_LANES-1:0][DATA_LEN-1:0]         fu_res_data,
  output logic [NUM_FU_LANES-1:0]                       fu_free,
  output logic [NUM_FU_LANES-1:0]                       fu_free_1c,
  output logic [CDB_NUM_LANES-1:0]                      commit_instr_cdb,
  output logic [CDB_NUM_LANES-1:0][ROB_SIZE_CLOG-1:0]   robid_cdb,
  output logic [CDB_NUM_LANES-1:0][OP_W-1:0]            op_cdb,
  output logic [CDB_NUM_LANES-1:0][RD_W-1:0]            rd_tag_cdb,
  output logic [CDB_NUM_LANES-1:0][DATA_LEN-1:0]        result_data_cdb
);

  localparam int PW = (NUM_FU_LANES > 1) ? $clog2(NUM_FU_LANES) : 1;
  localparam int OW = $clog2(WB_FIFO_DEPTH) + 1;

  cdb_pkt_t                 in_pkt   [NUM_FU_LANES];
  cdb_pkt_t                 head     [NUM_FU_LANES];
  logic [OW-1:0]            occ      [NUM_FU_LANES];
  logic [NUM_FU_LANES-1:0]  full, empty, cand;
  logic [NUM_FU_LANES-1:0]  grant, pop, push, byp;
  logic [PW-1:0]            rr_q, rr_d;
  logic [CDB_NUM_LANES-1:0] pv, commit_q;
  cdb_pkt_t                 port_pkt [CDB_NUM_LANES];
  cdb_pkt_t                 cdb_q    [CDB_NUM_LANES];

`ifdef CDB_BYPASS_EN
  assign cand = ~empty | fu_res_val;
`else
  assign cand = ~empty;
`endif

  always_comb begin
    int cnt;
    int lane;
    grant = '0;
    pv    = '0;
    rr_d  = rr_q;
    cnt   = 0;
    lane  = 0;
    for (int c = 0; c < CDB_NUM_LANES; c++) port_pkt[c] = '0;
    for (int i = 0; i < NUM_FU_LANES; i++) begin
      lane = lane_wrap(int'(rr_q) + i, NUM_FU_LANES);
      if (cand[lane] && cnt < CDB_NUM_LANES) begin
        grant[lane]   = 1'b1;
        pv[cnt]       = 1'b1;
        port_pkt[cnt] = empty[lane] ? in_pkt[lane] : head[lane];
        rr_d          = PW'(lane_wrap(lane + 1, NUM_FU_LANES));
        cnt           = cnt + 1;
      end
    end
  end

  assign pop        = grant & ~empty;
  assign byp        = grant & empty;
  assign fu_free_1c = full & grant;
  // A bypassed result is already on its way to the CDB, so it skips the FIFO.
  assign push       = fu_res_val & (fu_free | fu_free_1c) & ~byp;

  for (genvar l = 0; l < NUM_FU_LANES; l++) begin : g_lane
    assign in_pkt[l] = {fu_res_robid[l], fu_res_op[l],
                        fu_res_rd[l], fu_res_data[l]};
    assign fu_free[l] = (int'(occ[l]) < WB_FIFO_DEPTH);

    wb_fifo #(
      .DEPTH (WB_FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .flush_i (flush),
      .push_i  (push[l]),
      .pop_i   (pop[l]),
      .din_i   (in_pkt[l]),
      .dout_o  (head[l]),
      .full_o  (full[l]),
      .empty_o (empty[l]),
      .occ_o   (occ[l])
    );

    a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst || flush)
      !(fu_res_val[l] && !fu_free[l] && !fu_free_1c[l]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= '0;
      commit_q <= '0;
      for (int c = 0; c < CDB_NUM_LANES; c++) cdb_q[c] <= '0;
    end else if (flush) begin
      commit_q <= '0;
    end else begin
      rr_q     <= rr_d;
      commit_q <= pv;
      for (int c = 0; c < CDB_NUM_LANES; c++)
        if (pv[c]) cdb_q[c] <= port_pkt[c];
    end
  end

  assign commit_instr_cdb = commit_q;

  for (genvar c = 0; c < CDB_NUM_LANES; c++) begin : g_cdb
    assign robid_cdb[c]       = cdb_q[c].robid;
    assign op_cdb[c]          = cdb_q[c].op;
    assign rd_tag_cdb[c]      = cdb_q[c].rd;
    assign result_data_cdb[c] = cdb_q[c].data;
  end

endmodule

// File: tb/tb_cdb_wb_arb.sv
// Self-checking bench for cdb_wb_arb: vector table, directed corners, random vs queue model.
module tb_cdb_wb_arb;
  import cdb_wb_arb_pkg::*;

  localparam int NL = 6;
  localparam int NC = 4;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  logic [NL-1:0]        fu_res_val = '0;
  logic [NL-1:0][4:0]   fu_res_robid = '0;
  logic [NL-1:0][5:0]   fu_res_op = '0;
  logic [NL-1:0][4:0]   fu_res_rd = '0;
  logic [NL-1:0][31:0]  fu_res_data = '0;
  logic [NL-1:0]        fu_free, fu_free_1c;
  logic [NC-1:0]        commit_instr_cdb;
  logic [NC-1:0][4:0]   robid_cdb;
  logic [NC-1:0][5:0]   op_cdb;
  logic [NC-1:0][4:0]   rd_tag_cdb;
  logic [NC-1:0][31:0]  result_data_cdb;

  cdb_wb_arb #(.NUM_FU_LANES(NL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_res_val(fu_res_val), .fu_res_robid(fu_res_robid),
    .fu_res_op(fu_res_op), .fu_res_rd(fu_res_rd),
    .fu_res_data(fu_res_data),
    .fu_free(fu_free), .fu_free_1c(fu_free_1c),
    .commit_instr_cdb(commit_instr_cdb), .robid_cdb(robid_cdb),
    .op_cdb(op_cdb), .rd_tag_cdb(rd_tag_cdb),
    .result_data_cdb(result_data_cdb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per lane plus a scan pointer.
  cdb_pkt_t    mq [NL][$];
  int          mrr;
  bit          mg [NL];
  int          mg_lane [NC];
  int          mg_n;
  logic [NC-1:0] ev;
  cdb_pkt_t    ep [NC];
  int          nacc, nbc;

  function automatic cdb_pkt_t inpkt(input int l);
    return {fu_res_robid[l], fu_res_op[l], fu_res_rd[l], fu_res_data[l]};
  endfunction

  function automatic cdb_pkt_t dutpkt(input int c);
    return {robid_cdb[c], op_cdb[c], rd_tag_cdb[c], result_data_cdb[c]};
  endfunction

  function automatic cdb_pkt_t mkpkt(input int l);
    cdb_pkt_t p;
    p.robid = 5'(l + 8);
    p.op    = 6'(l + 32);
    p.rd    = 5'(l + 16);
    p.data  = 32'hC0DE0000 + 32'(l);
    return p;
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) mq[l].delete();
    mrr = 0;
    ev  = '0;
    for (int c = 0; c < NC; c++) ep[c] = '0;
  endfunction

  function automatic void model_arb();
    int n = 0;
    for (int l = 0; l < NL; l++) mg[l] = 0;
    for (int i = 0; i < NL; i++) begin
      int  lane = (mrr + i) % NL;
      bit  c    = mq[lane].size() > 0;
      if (BYP && fu_res_val[lane]) c = 1;
      if (c && n < NC) begin
        mg[lane]   = 1;
        mg_lane[n] = lane;
        n++;
      end
    end
    mg_n = n;
  endfunction

  function automatic void model_edge();
    bit bp [NL];
    for (int l = 0; l < NL; l++) bp[l] = 0;
    ev = '0;
    if (flush) begin
      for (int l = 0; l < NL; l++) mq[l].delete();
      return;
    end
    for (int n = 0; n < mg_n; n++) begin
      int lane = mg_lane[n];
      ev[n] = 1'b1;
      if (mq[lane].size() > 0) ep[n] = mq[lane].pop_front();
      else begin
        ep[n]    = inpkt(lane);
        bp[lane] = 1;
        nacc++;
      end
    end
    if (mg_n > 0) mrr = (mg_lane[mg_n-1] + 1) % NL;
    for (int l = 0; l < NL; l++)
      if (fu_res_val[l] && !bp[l] && mq[l].size() < WB_FIFO_DEPTH) begin
        mq[l].push_back(inpkt(l));
        nacc++;
      end
  endfunction

  task automatic clr_in();
    fu_res_val = '0;
  endtask

  task automatic drive(input int l, input cdb_pkt_t p);
    fu_res_val[l]   = 1'b1;
    fu_res_robid[l] = p.robid;
    fu_res_op[l]    = p.op;
    fu_res_rd[l]    = p.rd;
    fu_res_data[l]  = p.data;
  endtask

  function automatic cdb_pkt_t rndpkt();
    cdb_pkt_t p;
    p.robid = 5'($urandom);
    p.op    = 6'($urandom);
    p.rd    = 5'($urandom);
    p.data  = $urandom;
    return p;
  endfunction

  // Drop pushes the protocol forbids: full lanes that are not granted.
  task automatic legalize();
    model_arb();
    for (int l = 0; l < NL; l++)
      if (mq[l].size() >= WB_FIFO_DEPTH && !mg[l]) fu_res_val[l] = 1'b0;
  endtask

  task automatic tick();
    logic [NL-1:0] ef, e1c;
    model_arb();
    for (int l = 0; l < NL; l++) begin
      ef[l]  = mq[l].size() < WB_FIFO_DEPTH;
      e1c[l] = (mq[l].size() == WB_FIFO_DEPTH) && mg[l];
    end
    chk("fu_free", fu_free, ef);
    chk("fu_free_1c", fu_free_1c, e1c);
    model_edge();
    @(posedge clk); #1;
    nbc += $countones(commit_instr_cdb);
    chk("commit", commit_instr_cdb, ev);
    for (int c = 0; c < NC; c++)
      if (ev[c]) chk($sformatf("cdb_pkt%0d", c), dutpkt(c), ep[c]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    clr_in();
    model_reset();
    #2 rst = 1'b1;
  endtask

  typedef struct {
    logic [NL-1:0]      mask;
    logic [NC-1:0]      v1;
    logic [NC-1:0][2:0] l1;
    logic [NC-1:0]      v2;
    logic [NC-1:0][2:0] l2;
  } vec_t;

  localparam int NV = 6;
  vec_t tv [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int j;
    logic [NC-1:0]      xv;
    logic [NC-1:0][2:0] xl;
    bit seen_full, seen_1c;

    tv[0] = '{6'b000100, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2},
              4'b0000, '0};
    tv[1] = '{6'b111111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0},
              4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}};
    tv[2] = '{6'b100001, 4'b0011, {3'd0, 3'd0, 3'd5, 3'd0},
              4'b0000, '0};
    tv[3] = '{6'b101010, 4'b0111, {3'd0, 3'd5, 3'd3, 3'd1},
              4'b0000, '0};
    tv[4] = '{6'b011110, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1},
              4'b0000, '0};
    tv[5] = '{6'b110111, 4'b1111, {3'd4, 3'd2, 3'd1, 3'd0},
              4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}};

    model_reset();
    #1;
    chk("rst_commit", commit_instr_cdb, '0);
    chk("rst_fu_free", fu_free, 6'h3f);
    chk("rst_fu_free_1c", fu_free_1c, '0);
    chk("rst_robid", robid_cdb, '0);
    chk("rst_data", result_data_cdb, '0);
    #2 rst = 1'b1;

    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int l = 0; l < NL; l++)
        if (tv[v].mask[l]) drive(l, mkpkt(l));
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        clr_in();
        j  = k + (BYP ? 1 : 0);
        xv = (j == 1) ? tv[v].v1 : (j == 2) ? tv[v].v2 : '0;
        xl = (j == 1) ? tv[v].l1 : tv[v].l2;
        chk($sformatf("vec%0d_commit_k%0d", v, k), commit_instr_cdb, xv);
        for (int c = 0; c < NC; c++)
          if (xv[c])
            chk($sformatf("vec%0d_pkt%0d", v, c), dutpkt(c),
                mkpkt(int'(xl[c])));
      end
    end

    // Single result on lane 2
    do_reset();
    drive(2, '{robid: 5'd5, op: 6'd1, rd: 5'd7, data: 32'hDEADBEEF});
    tick();
    clr_in();
    chk("t1_commit_e0", commit_instr_cdb, BYP ? 4'b0001 : 4'b0000);
    tick();
    chk("t1_commit_e1", commit_instr_cdb, BYP ? 4'b0000 : 4'b0001);
    chk("t1_robid", robid_cdb[0], 5'd5);
    chk("t1_rd", rd_tag_cdb[0], 5'd7);
    chk("t1_data", result_data_cdb[0], 32'hDEADBEEF);
    repeat (2) tick();

    // Lane 1 pushes every cycle while the CDB is saturated
    do_reset();
    nacc = 0; nbc = 0;
    seen_full = 0; seen_1c = 0;
    for (int i = 0; i < 30; i++) begin
      for (int l = 0; l < NL; l++) drive(l, rndpkt());
      legalize();
      #0;
      if (!fu_free[1]) seen_full = 1;
      if (fu_free_1c[1]) seen_1c = 1;
      tick();
      clr_in();
    end
    repeat (6) tick();
    chk("t3_l1_full_seen", seen_full, 1'b1);
    chk("t3_l1_1c_seen", seen_1c, 1'b1);
    chk("t3_no_loss", 64'(nbc), 64'(nacc));

    // Flush with three lanes buffered and a push on lane 0
    do_reset();
    for (int l = 1; l <= 3; l++) drive(l, rndpkt());
    tick();
    clr_in();
    flush = 1'b1;
    drive(0, rndpkt());
    tick();
    flush = 1'b0;
    clr_in();
    chk("t4_commit", commit_instr_cdb, '0);
    chk("t4_fu_free", fu_free, 6'h3f);
    repeat (3) tick();
    chk("t4_quiet", commit_instr_cdb, '0);

    // Pointer wrap: rr at 5, lanes 5 and 0 pending
    do_reset();
    for (int l = 0; l < 5; l++) drive(l, mkpkt(l));
    tick();
    clr_in();
    repeat (3) tick();
    drive(5, '{robid: 5'd21, op: 6'd0, rd: 5'd0, data: 32'h5});
    drive(0, '{robid: 5'd20, op: 6'd0, rd: 5'd0, data: 32'h0});
    tick();
    clr_in();
    tick();
    chk("t5_port0_lane5", robid_cdb[0], 5'd21);
    chk("t5_port1_lane0", robid_cdb[1], 5'd20);
    drive(0, '{robid: 5'd30, op: 6'd0, rd: 5'd0, data: 32'h0});
    drive(1, '{robid: 5'd31, op: 6'd0, rd: 5'd0, data: 32'h1});
    tick();
    clr_in();
    tick();
    chk("t5_rr1_port0", robid_cdb[0], 5'd31);
    chk("t5_rr1_port1", robid_cdb[1], 5'd30);

`ifdef CDB_BYPASS_EN
    do_reset();
    drive(3, '{robid: 5'd9, op: 6'd2, rd: 5'd3, data: 32'h99});
    tick();
    clr_in();
    chk("t6_byp_commit", commit_instr_cdb, 4'b0001);
    chk("t6_byp_robid", robid_cdb[0], 5'd9);
    tick();
    chk("t6_fifo_empty", commit_instr_cdb, '0);
`endif

    // Random traffic with occasional flush and one mid-run reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < NL; l++)
        if ($urandom_range(1, 0) == 1) drive(l, rndpkt());
      flush = ($urandom_range(99, 0) < 4);
      legalize();
      tick();
      clr_in();
      flush = 1'b0;
      if (i == 200) begin
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_commit", commit_instr_cdb, '0);
        chk("mid_rst_fu_free", fu_free, 6'h3f);
        chk("mid_rst_fu_free_1c", fu_free_1c, '0);
        chk("mid_rst_robid", robid_cdb, '0);
        model_reset();
        #1 rst = 1'b1;
      end
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
